// File: rtl/huffman_pkg.sv
// huffman_pkg: shared phase codes, sequencer state encoding and count widths
// for the Huffman frame sequencer and its step handshake helper.
package huffman_pkg;

  // Phase codes presented to the encoder datapath on enc_phase.
  localparam logic [2:0] PHASE_INIT         = 3'd0;
  localparam logic [2:0] PHASE_FREQ_COUNT   = 3'd1;
  localparam logic [2:0] PHASE_SORT         = 3'd2;
  localparam logic [2:0] PHASE_BUILD_TREE   = 3'd3;
  localparam logic [2:0] PHASE_GEN_CODE     = 3'd4;
  localparam logic [2:0] PHASE_SEND_SYMBOLS = 3'd5;
  localparam logic [2:0] PHASE_SEND_CODE    = 3'd6;
  localparam logic [2:0] PHASE_SEND_LENGTH  = 3'd7;

  // Widths of the distinct-symbol count and the merge/header indices.
  localparam int SYM_CNT_W = 9;
  localparam int IDX_W     = 8;

  // Sequencer states. ST_ERR is only reachable with the watchdog built in.
  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_COLLECT      = 3'd1,
    ST_SORT         = 3'd2,
    ST_BUILD_TREE   = 3'd3,
    ST_GEN_CODE     = 3'd4,
    ST_SEND_SYMBOLS = 3'd5,
    ST_DONE         = 3'd6,
    ST_ERR          = 3'd7
  } seq_state_e;

  // Phase code shown to the datapath while the sequencer sits in a state.
  function automatic logic [2:0] phase_of(seq_state_e s);
    case (s)
      ST_COLLECT:      return PHASE_FREQ_COUNT;
      ST_SORT:         return PHASE_SORT;
      ST_BUILD_TREE:   return PHASE_BUILD_TREE;
      ST_GEN_CODE:     return PHASE_GEN_CODE;
      ST_SEND_SYMBOLS: return PHASE_SEND_SYMBOLS;
      default:         return PHASE_INIT;
    endcase
  endfunction

endpackage

// File: rtl/huffman_step_handshake.sv
// huffman_step_handshake: start pulse / done qualification for one datapath
// step, shared by every step state of the frame sequencer.
// Optional watchdog: define HUFF_PHASE_TIMEOUT_EN to build the per-step
// cycle counter; without it timeout is tied low and steps wait forever.
//
// Handshake: the owner raises launch for exactly one cycle to begin a step;
// that cycle is the phase_start pulse. phase_done is only honoured from the
// cycle after launch until the first accepted done (step_done), so a done in
// the launch cycle or with no step pending is dropped.
module huffman_step_handshake #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clock,
  input  logic rst,
  input  logic launch,
  input  logic phase_done,
  input  logic stall,
  output logic phase_start,
  output logic step_done,
  output logic timeout
);

  logic pending;

  assign phase_start = launch;
  assign step_done   = pending & phase_done;

  // A step is pending from the cycle after launch until its done is taken.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
    end else if (launch) begin
      pending <= 1'b1;
    end else if (step_done) begin
      pending <= 1'b0;
    end
  end

`ifdef HUFF_PHASE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] wait_cnt;
  logic          waiting;

  // Waiting covers an outstanding step and a stalled header entry.
  assign waiting = (pending & ~phase_done) | stall;

  // Count consecutive waiting cycles; any progress or a new step clears it.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (launch || !waiting) begin
      wait_cnt <= '0;
    end else if (!timeout) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  assign timeout = waiting && !launch && (wait_cnt == TW'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = stall ^ TIMEOUT_CYC[0];
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/huffman_frame_sequencer.sv
// huffman_frame_sequencer: gates one frame of symbols into the frequency
// counter, then walks the encoder through sort, tree build (one merge per
// step), code generation and header emission. One frame in flight.
// Optional watchdog: define HUFF_PHASE_TIMEOUT_EN to enable the sticky ERR
// state; otherwise err is tied low.
//
// Handshakes: a symbol moves when in_valid && in_ready; a header entry moves
// when hdr_valid && hdr_ready, and hdr_idx is held stable while stalled.
module huffman_frame_sequencer
  import huffman_pkg::*;
#(
  parameter int BIT_WIDTH   = 7,
  parameter int MAX_SYMBOL  = 255,
  parameter int FRAME_LEN   = 100,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 enc_data_enable,
  output logic [2:0]           enc_phase,
  output logic                 enc_phase_start,
  input  logic                 enc_phase_done,
  input  logic [SYM_CNT_W-1:0] enc_symbol_count,
  output logic [IDX_W-1:0]     merge_idx,
  output logic [IDX_W-1:0]     hdr_idx,
  output logic                 hdr_valid,
  input  logic                 hdr_ready,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 err,
  output seq_state_e           dbg_state
);

  localparam int DATA_W = $clog2(FRAME_LEN + 1);
  // Largest meaningful symbol count: bounded by the table and the symbol width.
  localparam int SYM_SPACE  = 1 << (BIT_WIDTH + 1);
  localparam int TABLE_SIZE = (MAX_SYMBOL + 1 < SYM_SPACE) ? MAX_SYMBOL + 1 : SYM_SPACE;

  seq_state_e           state, state_d;
  logic [DATA_W-1:0]    data_cnt, data_cnt_d;
  logic [SYM_CNT_W-1:0] sym_cnt, sym_cnt_d;
  logic [IDX_W-1:0]     merge_idx_d, hdr_idx_d;
  logic                 launch_q, launch_d;
  logic [SYM_CNT_W-1:0] sym_clamped;
  logic                 step_done;
  logic                 step_timeout;

  huffman_step_handshake #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_step (
    .clock       (clock),
    .rst         (rst),
    .launch      (launch_q),
    .phase_done  (enc_phase_done),
    .stall       (hdr_valid & ~hdr_ready),
    .phase_start (enc_phase_start),
    .step_done   (step_done),
    .timeout     (step_timeout)
  );

  // Keep the symbol count in 1..TABLE_SIZE so the merge/header loops end.
  always_comb begin
    sym_clamped = enc_symbol_count;
    if (enc_symbol_count == '0) begin
      sym_clamped = SYM_CNT_W'(1);
    end else if (enc_symbol_count > SYM_CNT_W'(TABLE_SIZE)) begin
      sym_clamped = SYM_CNT_W'(TABLE_SIZE);
    end
  end

  // Next-state and counter updates for the frame sequence.
  always_comb begin
    state_d     = state;
    data_cnt_d  = data_cnt;
    sym_cnt_d   = sym_cnt;
    merge_idx_d = merge_idx;
    hdr_idx_d   = hdr_idx;
    launch_d    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_COLLECT;
          data_cnt_d  = '0;
          merge_idx_d = '0;
          hdr_idx_d   = '0;
        end
      end
      ST_COLLECT: begin
        if (in_valid) begin
          data_cnt_d = data_cnt + 1'b1;
          if (in_last || data_cnt == DATA_W'(FRAME_LEN - 1)) begin
            state_d  = ST_SORT;
            launch_d = 1'b1;
          end
        end
      end
      ST_SORT: begin
        if (step_done) begin
          sym_cnt_d   = sym_clamped;
          merge_idx_d = '0;
          launch_d    = 1'b1;
          // A single distinct symbol needs no merges at all.
          state_d     = (sym_clamped == SYM_CNT_W'(1)) ? ST_GEN_CODE : ST_BUILD_TREE;
        end
      end
      ST_BUILD_TREE: begin
        if (step_done) begin
          merge_idx_d = merge_idx + 1'b1;
          launch_d    = 1'b1;
          // Last merge when merge_idx + 1 reaches sym_cnt - 1.
          if ({1'b0, merge_idx} + SYM_CNT_W'(2) == sym_cnt) begin
            state_d = ST_GEN_CODE;
          end
        end
      end
      ST_GEN_CODE: begin
        if (step_done) begin
          state_d   = ST_SEND_SYMBOLS;
          hdr_idx_d = '0;
        end
      end
      ST_SEND_SYMBOLS: begin
        if (hdr_ready) begin
          if ({1'b0, hdr_idx} + SYM_CNT_W'(1) == sym_cnt) begin
            state_d = ST_DONE;
          end else begin
            hdr_idx_d = hdr_idx + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
`ifdef HUFF_PHASE_TIMEOUT_EN
    if (step_timeout && state != ST_IDLE && state != ST_ERR) begin
      state_d  = ST_ERR;
      launch_d = 1'b0;
    end
`endif
  end

  // State, counters and the registered launch pulse.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      data_cnt  <= '0;
      sym_cnt   <= '0;
      merge_idx <= '0;
      hdr_idx   <= '0;
      launch_q  <= 1'b0;
    end else begin
      state     <= state_d;
      data_cnt  <= data_cnt_d;
      sym_cnt   <= sym_cnt_d;
      merge_idx <= merge_idx_d;
      hdr_idx   <= hdr_idx_d;
      launch_q  <= launch_d;
    end
  end

  assign in_ready        = (state == ST_COLLECT);
  assign enc_data_enable = in_valid & in_ready;
  assign enc_phase       = phase_of(state);
  assign hdr_valid       = (state == ST_SEND_SYMBOLS);
  assign busy            = (state != ST_IDLE);
  assign frame_done      = (state == ST_DONE);
  assign dbg_state       = state;

`ifdef HUFF_PHASE_TIMEOUT_EN
  assign err = (state == ST_ERR);
`else
  logic unused_step_timeout;
  assign unused_step_timeout = step_timeout;
  assign err = 1'b0;
`endif

endmodule
